// File: rtl/imm_pkg.sv
// Shared immediate-type codes and occupancy states for imm_gen_pipe.
// Optional RVC CI-type decode on code 7 is enabled by defining IMM_RVC_EN.
package imm_pkg;

    localparam logic [2:0] IMM_SEL_ILLEGAL = 3'd0;
    localparam int unsigned IMM_ZX_BIT = 3;

    typedef enum logic [2:0] {
        IMM_TYPE_ILL   = IMM_SEL_ILLEGAL,
        IMM_TYPE_U     = 3'd1,
        IMM_TYPE_J     = 3'd2,
        IMM_TYPE_I     = 3'd3,
        IMM_TYPE_B     = 3'd4,
        IMM_TYPE_S     = 3'd5,
        IMM_TYPE_SHAMT = 3'd6,
        IMM_TYPE_RVC   = 3'd7
    } imm_type_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction and extension for XLEN = 32 or 64.
// Code 7 decodes RVC CI-type when IMM_RVC_EN is defined, otherwise it is illegal.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  logic [3:0]      imm_sel,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    localparam int SHAMT_W = $clog2(XLEN);

    logic        w_zx;
    logic        w_sext;
    logic [31:0] w_v32;
    logic        w_unused;

    assign w_zx     = imm_sel[IMM_ZX_BIT];
    assign w_unused = ^inst[6:0];

    // Every field is first extended to 32 bits; w_sext then says whether bit 31 replicates up to XLEN.
    always_comb begin
        w_v32  = '0;
        w_sext = 1'b0;
        err    = 1'b0;
        case (imm_type_e'(imm_sel[2:0]))
            IMM_TYPE_U: begin
                w_v32  = {inst[31:12], 12'b0};
                w_sext = 1'b1;
            end
            IMM_TYPE_J: begin
                w_v32  = {{11{inst[31] & ~w_zx}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                w_sext = ~w_zx;
            end
            IMM_TYPE_I: begin
                w_v32  = {{20{inst[31] & ~w_zx}}, inst[31:20]};
                w_sext = ~w_zx;
            end
            IMM_TYPE_B: begin
                w_v32  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                w_sext = 1'b1;
            end
            IMM_TYPE_S: begin
                w_v32  = {{20{inst[31] & ~w_zx}}, inst[31:25], inst[11:7]};
                w_sext = ~w_zx;
            end
            IMM_TYPE_SHAMT: begin
                w_v32  = 32'(inst[20 +: SHAMT_W]);
            end
`ifdef IMM_RVC_EN
            IMM_TYPE_RVC: begin
                w_v32  = {{26{inst[12] & ~w_zx}}, inst[12], inst[6:2]};
                w_sext = ~w_zx;
            end
`endif
            default: begin
                err    = 1'b1;
            end
        endcase
    end

    assign imm = w_sext ? XLEN'($signed(w_v32)) : XLEN'(w_v32);

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode, output register plus skid entry, flush.
// Build option IMM_RVC_EN (handled in imm_decode) adds RVC CI-type on code 7.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [3:0]       imm_sel,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_ext,
    output logic [TAG_W-1:0] out_tag,
    output logic             imm_err
);

    occ_e             r_state;
    occ_e             w_next;
    logic             r_in_ready;
    logic [XLEN-1:0]  r_a_imm, r_b_imm;
    logic [TAG_W-1:0] r_a_tag, r_b_tag;
    logic             r_a_err, r_b_err;

    logic [XLEN-1:0]  w_dec_imm;
    logic             w_dec_err;
    logic             w_accept, w_drain;
    logic             w_load_a_new, w_load_a_b, w_load_b;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst    (inst),
        .imm_sel (imm_sel),
        .imm     (w_dec_imm),
        .err     (w_dec_err)
    );

    assign w_accept  = in_valid && r_in_ready;
    assign w_drain   = out_valid && out_ready;
    assign out_valid = (r_state != OCC_EMPTY);
    assign in_ready  = r_in_ready;
    assign imm_ext   = r_a_imm;
    assign out_tag   = r_a_tag;
    assign imm_err   = r_a_err;

    // in_ready resets low and mirrors "skid entry free" from the first edge after reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= OCC_EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != OCC_FULL);
        end
    end

    always_comb begin
        w_next       = r_state;
        w_load_a_new = 1'b0;
        w_load_a_b   = 1'b0;
        w_load_b     = 1'b0;
        if (flush) begin
            w_next = OCC_EMPTY;
        end else begin
            case (r_state)
                OCC_EMPTY: begin
                    if (w_accept) begin
                        w_next       = OCC_ONE;
                        w_load_a_new = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (w_accept && w_drain) begin
                        w_load_a_new = 1'b1;
                    end else if (w_accept) begin
                        w_next   = OCC_FULL;
                        w_load_b = 1'b1;
                    end else if (w_drain) begin
                        w_next = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (w_drain) begin
                        w_next     = OCC_ONE;
                        w_load_a_b = 1'b1;
                    end
                end
                default: w_next = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_a_imm <= '0;
            r_a_tag <= '0;
            r_a_err <= 1'b0;
            r_b_imm <= '0;
            r_b_tag <= '0;
            r_b_err <= 1'b0;
        end else begin
            if (w_load_a_new) begin
                r_a_imm <= w_dec_imm;
                r_a_tag <= in_tag;
                r_a_err <= w_dec_err;
            end else if (w_load_a_b) begin
                r_a_imm <= r_b_imm;
                r_a_tag <= r_b_tag;
                r_a_err <= r_b_err;
            end
            if (w_load_b) begin
                r_b_imm <= w_dec_imm;
                r_b_tag <= in_tag;
                r_b_err <= w_dec_err;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus
// and are compared against a FIFO reference model with arithmetic immediate decoding.
module tb_imm_gen_pipe;

    localparam int TAG_W = 5;

    logic             CLK = 1'b0;
    logic             RESET_N = 1'b0;
    logic             in_valid = 1'b0;
    logic             flush = 1'b0;
    logic             out_ready = 1'b0;
    logic [31:0]      inst = '0;
    logic [3:0]       imm_sel = '0;
    logic [TAG_W-1:0] in_tag = '0;

    logic             in_ready32, out_valid32, imm_err32;
    logic [31:0]      imm_ext32;
    logic [TAG_W-1:0] out_tag32;
    logic             in_ready64, out_valid64, imm_err64;
    logic [63:0]      imm_ext64;
    logic [TAG_W-1:0] out_tag64;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [63:0]      imm32;
        logic [63:0]      imm64;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    exp_t             q[$];
    bit               model_ready = 1'b0;
    logic [TAG_W-1:0] seen_tags[$];

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
        .CLK(CLK), .RESET_N(RESET_N), .in_valid(in_valid), .in_ready(in_ready32),
        .inst(inst), .imm_sel(imm_sel), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid32), .out_ready(out_ready), .imm_ext(imm_ext32),
        .out_tag(out_tag32), .imm_err(imm_err32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .CLK(CLK), .RESET_N(RESET_N), .in_valid(in_valid), .in_ready(in_ready64),
        .inst(inst), .imm_sel(imm_sel), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid64), .out_ready(out_ready), .imm_ext(imm_ext64),
        .out_tag(out_tag64), .imm_err(imm_err64)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Field value and width taken straight from the encoding tables, then extended arithmetically.
    function automatic void ref_dec(input logic [31:0] i, input logic [3:0] s, input int xlen,
                                    output logic [63:0] imm, output logic err);
        longint unsigned f;
        int              w;
        bit              sx;
        f   = 0;
        w   = 1;
        sx  = (s[3] == 1'b0);
        err = 1'b0;
        case (s[2:0])
            3'd1: begin f = 64'(i[31:12]) << 12; w = 32; sx = 1'b1; end
            3'd2: begin f = 64'({i[31], i[19:12], i[20], i[30:21], 1'b0}); w = 21; end
            3'd3: begin f = 64'(i[31:20]); w = 12; end
            3'd4: begin f = 64'({i[31], i[7], i[30:25], i[11:8], 1'b0}); w = 13; sx = 1'b1; end
            3'd5: begin f = 64'({i[31:25], i[11:7]}); w = 12; end
            3'd6: begin
                w  = (xlen == 64) ? 6 : 5;
                f  = 64'((i >> 20) & ((32'd1 << w) - 32'd1));
                sx = 1'b0;
            end
            3'd7: begin
`ifdef IMM_RVC_EN
                f = 64'({i[12], i[6:2]});
                w = 6;
`else
                err = 1'b1;
                sx  = 1'b0;
`endif
            end
            default: begin err = 1'b1; sx = 1'b0; end
        endcase
        if (sx && f[w-1]) f = f - (64'd1 << w);
        imm = (xlen == 32) ? (f & 64'hFFFF_FFFF) : f;
    endfunction

    task automatic check_outputs();
        check("out_valid32", out_valid32, q.size() != 0);
        check("out_valid64", out_valid64, q.size() != 0);
        check("in_ready32", in_ready32, model_ready);
        check("in_ready64", in_ready64, model_ready);
        if (q.size() != 0) begin
            check("imm32", imm_ext32, q[0].imm32[31:0]);
            check("imm64", imm_ext64, q[0].imm64);
            check("tag32", out_tag32, q[0].tag);
            check("tag64", out_tag64, q[0].tag);
            check("err32", imm_err32, q[0].err);
            check("err64", imm_err64, q[0].err);
        end
    endtask

    // Called just after a falling edge: drive, advance the model on the rising edge, check on the next fall.
    task automatic step(input bit v, input logic [31:0] i, input logic [3:0] s,
                        input logic [TAG_W-1:0] t, input bit ordy, input bit fl, output bit acc);
        exp_t e;
        bit   drn;
        logic err64;
        in_valid  = v;
        inst      = i;
        imm_sel   = s;
        in_tag    = t;
        out_ready = ordy;
        flush     = fl;
        acc = v && model_ready && !fl;
        drn = (q.size() != 0) && ordy;
        if (drn && !fl) seen_tags.push_back(out_tag32);
        ref_dec(i, s, 32, e.imm32, e.err);
        ref_dec(i, s, 64, e.imm64, err64);
        e.tag = t;
        @(posedge CLK);
        if (fl) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        model_ready = (q.size() < 2);
        @(negedge CLK);
        check_outputs();
    endtask

    task automatic idle(input int n);
        bit a;
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, '0, 1'b1, 1'b0, a);
    endtask

    initial begin
        bit a;
        int tries;

        // Reset state
        #1;
        check("rst_out_valid", out_valid32, 1'b0);
        check("rst_in_ready", in_ready32, 1'b0);
        check("rst_imm", imm_ext32, '0);
        check("rst_tag", out_tag32, '0);
        check("rst_err", imm_err32, 1'b0);
        check("rst_imm64", imm_ext64, '0);
        @(negedge CLK);
        RESET_N = 1'b1;
        check("rel_in_ready_low", in_ready32, 1'b0);
        idle(1);
        check("rel_in_ready_high", in_ready32, 1'b1);

        // I-type sign and zero extension, latency 1, back-to-back through ONE
        step(1'b1, 32'hFFF00093, 4'b0011, 5'd1, 1'b1, 1'b0, a);
        check("I_sext", imm_ext32, 32'hFFFFFFFF);
        step(1'b1, 32'hFFF00093, 4'b1011, 5'd2, 1'b1, 1'b0, a);
        check("I_zext", imm_ext32, 32'h00000FFF);
        step(1'b1, 32'hFE000EE3, 4'b0100, 5'd3, 1'b1, 1'b0, a);
        check("B_32", imm_ext32, 32'hFFFFFFFC);
        check("B_64", imm_ext64, 64'hFFFFFFFFFFFFFFFC);
        idle(2);

        // Backpressure: two fill A and B, the third waits for in_ready
        seen_tags.delete();
        step(1'b1, $urandom, 4'd3, 5'd1, 1'b0, 1'b0, a);
        step(1'b1, $urandom, 4'd5, 5'd2, 1'b0, 1'b0, a);
        check("bp_ready_drop", in_ready32, 1'b0);
        step(1'b1, 32'h12345678, 4'd2, 5'd3, 1'b0, 1'b0, a);
        check("bp_tag3_held", a, 1'b0);
        check("bp_out_stable", out_tag32, 5'd1);
        tries = 0;
        a = 1'b0;
        while (!a && tries < 20) begin
            step(1'b1, 32'h12345678, 4'd2, 5'd3, 1'b1, 1'b0, a);
            tries++;
        end
        check("bp_tag3_accepted", a, 1'b1);
        idle(3);
        check("bp_count", seen_tags.size(), 3);
        for (int k = 0; k < 3 && k < seen_tags.size(); k++)
            check("bp_order", seen_tags[k], 5'(k + 1));

        // Flush in FULL with a simultaneous offer
        step(1'b1, $urandom, 4'd1, 5'd4, 1'b0, 1'b0, a);
        step(1'b1, $urandom, 4'd1, 5'd5, 1'b0, 1'b0, a);
        step(1'b1, $urandom, 4'd3, 5'd7, 1'b0, 1'b1, a);
        check("flush_out_valid", out_valid32, 1'b0);
        check("flush_in_ready", in_ready32, 1'b1);
        idle(2);
        check("flush_no_ghost", out_valid32, 1'b0);

        // Illegal and optional codes
        step(1'b1, 32'hDEADBEEF, 4'd0, 5'd8, 1'b1, 1'b0, a);
        check("sel0_imm", imm_ext32, '0);
        check("sel0_err", imm_err32, 1'b1);
`ifdef IMM_RVC_EN
        step(1'b1, 32'h0000107D, 4'd7, 5'd9, 1'b1, 1'b0, a);
        check("rvc_imm", imm_ext32, 32'hFFFFFFFF);
        check("rvc_err", imm_err32, 1'b0);
`else
        step(1'b1, 32'h0000107D, 4'd7, 5'd9, 1'b1, 1'b0, a);
        check("sel7_imm", imm_ext32, '0);
        check("sel7_err", imm_err32, 1'b1);
`endif
        idle(2);

        // Asynchronous reset while holding one entry
        step(1'b1, $urandom, 4'd3, 5'd10, 1'b0, 1'b0, a);
        in_valid = 1'b0;
        #2;
        RESET_N = 1'b0;
        #1;
        check("arst_out_valid32", out_valid32, 1'b0);
        check("arst_out_valid64", out_valid64, 1'b0);
        check("arst_in_ready", in_ready32, 1'b0);
        q.delete();
        model_ready = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        idle(1);
        check("arst_ready_back", in_ready32, 1'b1);
        check("arst_no_stale", out_valid32, 1'b0);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                 TAG_W'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), a);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the ID-stage immediate extender.
- Decodes the immediate for XLEN = 32 or 64 and registers the result in one output stage.
- A 2-entry skid buffer decouples ID from EX backpressure.
- Carries an instruction tag alongside the immediate and supports a pipeline flush.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64.
- TAG_W, 5, width of the sideband tag (ROB/PC index) carried with each immediate.
- SHAMT_W, $clog2(XLEN), shift-amount field width. It is derived and must not be overridden.

Ports:
- CLK  input  1  rising-edge clock.
- RESET_N  input  1  asynchronous, active-low reset.
- in_valid  input  1  an instruction is presented.
- in_ready  output  1  block can accept an instruction this cycle.
- inst  input  32  raw instruction word.
- imm_sel  input  4  bits [2:0] select the immediate type; bit [3] = zero-extend instead of sign-extend.
- in_tag  input  TAG_W  sideband tag.
- flush  input  1  synchronous kill of all held entries.
- out_valid  output  1  imm_ext/out_tag are valid.
- out_ready  input  1  consumer accepts this cycle.
- imm_ext  output  XLEN  extended immediate.
- out_tag  output  TAG_W  tag of the entry at the output.
- imm_err  output  1  the output entry had an illegal imm_sel (value 0 or 7).

Behaviour:
- Decode (combinational, before capture). Shown for XLEN=32; for XLEN=64 every extension widens to 64 bits.
  - U (1): {inst[31:12], 12'b0}, sign-extended from bit 31 for XLEN=64.
  - J (2): {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}, a 21-bit field.
  - I (3): inst[31:20].
  - B (4): {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - S (5): {inst[31:25], inst[11:7]}.
  - SHAMT (6): inst[20+SHAMT_W-1:20], always zero-extended.
  - Codes 0 and 7: imm = 0 and imm_err = 1.
- Extension rule:
  - imm_sel[3] = 0 sign-extends the field to XLEN from its top bit.
  - imm_sel[3] = 1 zero-extends the field.
  - imm_sel[3] is ignored for U, B and SHAMT: U and B are always sign-extended, SHAMT is always zero-extended.
- Storage: an output register (entry A) plus a skid register (entry B). Each entry holds {imm, tag, err, valid}.
- Handshake:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - in_ready = !B.valid (registered).
  - out_valid = A.valid.
- Occupancy states: EMPTY (A and B invalid), ONE (A valid only), FULL (A and B valid).
  - EMPTY + accept -> ONE. Data is visible on the output the next cycle: latency 1.
  - ONE + accept + drain -> ONE. A is loaded with the new entry.
  - ONE + accept, no drain -> FULL. The new entry goes to B.
  - ONE + drain, no accept -> EMPTY.
  - FULL + drain -> ONE. B moves to A. in_ready was 0, so no accept is possible.
  - FULL, no drain -> FULL. The output holds stable.
- Ordering: entries leave in strict FIFO order. While out_valid is high and out_ready is low, imm_ext/out_tag/imm_err must not change.
- flush:
  - Next state is EMPTY, with A.valid = B.valid = 0 and in_ready = 1.
  - flush has priority over any accept or drain in the same cycle. An input offered in the flush cycle is discarded.
- Reset (RESET_N low, asynchronous):
  - Outputs: out_valid = 0, in_ready = 0 while RESET_N is asserted, in_ready = 1 from the first clock after deassertion, imm_ext = 0, out_tag = 0, imm_err = 0.
  - Both entries are cleared.
  - Reset asserted mid-transfer drops all entries without producing an output.
- Data registers on invalid entries hold their last value. Verification compares data only when out_valid = 1.

Optional Feature:
- IMM_RVC_EN defined: imm_sel[2:0] = 7 selects RVC CI-type, {inst[12], inst[6:2]}, a 6-bit field sign-extended (or zero-extended when imm_sel[3] = 1). It does not raise imm_err.
- IMM_RVC_EN undefined: code 7 yields imm = 0 with imm_err = 1.

Decomposition:
- Shared package imm_pkg holds:
  - IMM_TYPE_U/J/I/B/S/SHAMT/RVC codes, values 1..7.
  - The imm_sel unsigned-bit index (3).
  - The illegal-code constant 0.
- One sub-module, imm_decode: combinational, parametrised by XLEN, inst/imm_sel -> imm/err.
- imm_gen_pipe contains only the handshake, skid buffer and flush logic.

Test Plan:
- XLEN=32, I-type inst=32'hFFF00093, imm_sel=4'b0011 -> imm_ext=32'hFFFFFFFF one cycle later. With imm_sel=4'b1011 -> 32'h00000FFF.
- B-type inst=32'hFE000EE3, imm_sel=4 -> imm_ext=32'hFFFFFFFC. With XLEN=64 -> 64'hFFFFFFFFFFFFFFFC.
- Backpressure:
  - Stimulus: out_ready=0, three back-to-back valid inputs with tags 1, 2, 3.
  - Required: in_ready drops after the second input is accepted, and tag 3 is held off until in_ready returns to 1.
  - Then out_ready=1 -> outputs tags 1, 2, 3 in order with no loss and no duplication.
- flush in the FULL state with a simultaneous input -> next cycle out_valid=0 and in_ready=1; the offered entry never appears.
- imm_sel=0 -> imm_ext=0, imm_err=1. imm_sel=7 -> imm_err=1 without IMM_RVC_EN.
  - With IMM_RVC_EN: inst[15:0]=16'h107D, CI-type field 111111, imm_sel=7 -> imm_ext=32'hFFFFFFFF, imm_err=0.
- RESET_N asserted asynchronously mid-cycle in the ONE state -> out_valid falls immediately.
  - After release: in_ready=1 on the next edge and no stale entry is emitted.
